// File: rtl/servo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : servo_pkg
// Brief    : Shared widths, default limits, debounce state encoding and
//            saturating step helpers for the servo command stage.
// Revision : 1.0 - initial release
// ============================================================================
package servo_pkg;

  localparam int POS_W = 12;

  localparam int DEF_POS_MIN = 500;
  localparam int DEF_POS_MAX = 2500;
  localparam int DEF_POS_RST = 1500;
  localparam int DEF_STEP    = 10;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_e;

  // Add one step with an extra carry bit so a sum above the limit saturates
  function automatic logic [POS_W-1:0] sat_add(input logic [POS_W-1:0] val,
                                               input logic [POS_W-1:0] step,
                                               input logic [POS_W-1:0] lim);
    logic [POS_W:0] sum;
    sum = {1'b0, val} + {1'b0, step};
    return (sum > {1'b0, lim}) ? lim : sum[POS_W-1:0];
  endfunction

  // Subtract one step; a borrow out of the top bit also means "below limit"
  function automatic logic [POS_W-1:0] sat_sub(input logic [POS_W-1:0] val,
                                               input logic [POS_W-1:0] step,
                                               input logic [POS_W-1:0] lim);
    logic [POS_W:0] diff;
    diff = {1'b0, val} - {1'b0, step};
    return (diff[POS_W] || (diff[POS_W-1:0] < lim)) ? lim : diff[POS_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module   : btn_debounce
// Brief    : 2-flop synchronizer plus four-state debounce FSM for one
//            active-low push-button; emits a one-cycle press pulse.
//            Optional auto-repeat while held: SERVO_AUTOREPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module btn_debounce import servo_pkg::*; #(
  parameter int DEB_CYCLES = 1_000_000
`ifdef SERVO_AUTOREPEAT_EN
  ,
  parameter int REPEAT_CYCLES = 15_000_000
`endif
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic btn_ni,
  output logic press_o
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEB_CYCLES - 1);

`ifdef SERVO_AUTOREPEAT_EN
  localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [REP_W-1:0] C_REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0] rep_q;
`endif

  logic [1:0]       sync_q;
  deb_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             press_q;

  // Bring the raw key into the clock domain; resets to the released level
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], btn_ni};
    end
  end

  // Debounce FSM: a level must hold DEB_CYCLES samples before it is accepted
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      press_q <= 1'b0;
`ifdef SERVO_AUTOREPEAT_EN
      rep_q   <= '0;
`endif
    end else begin
      press_q <= 1'b0;
      case (state_q)
        RELEASED: begin
          if (!sync_q[1]) begin
            state_q <= PRESS_WAIT;
            cnt_q   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (sync_q[1]) begin
            state_q <= RELEASED;
          end else if (cnt_q == C_CNT_LAST) begin
            state_q <= HELD;
            press_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HELD: begin
          if (sync_q[1]) begin
            state_q <= RELEASE_WAIT;
            cnt_q   <= '0;
`ifdef SERVO_AUTOREPEAT_EN
            rep_q   <= '0;
          end else if (rep_q == C_REP_LAST) begin
            press_q <= 1'b1;
            rep_q   <= '0;
          end else begin
            rep_q <= rep_q + 1'b1;
`endif
          end
        end
        RELEASE_WAIT: begin
          if (!sync_q[1]) begin
            state_q <= HELD;
          end else if (cnt_q == C_CNT_LAST) begin
            state_q <= RELEASED;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= RELEASED;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign press_o = press_q;

endmodule
`default_nettype wire

// File: rtl/servo_pos_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : servo_pos_ctrl
// Brief    : Button-driven target registers with saturation and a slew-limited
//            ramp of the X/Y/Z pulse-width commands toward their targets.
//            Optional auto-repeat of held buttons: SERVO_AUTOREPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module servo_pos_ctrl import servo_pkg::*; #(
  parameter int DEB_CYCLES = 1_000_000,
  parameter int RAMP_DIV   = 50_000,
  parameter int STEP       = DEF_STEP,
  parameter int POS_MIN    = DEF_POS_MIN,
  parameter int POS_MAX    = DEF_POS_MAX,
  parameter int POS_RST    = DEF_POS_RST
`ifdef SERVO_AUTOREPEAT_EN
  ,
  parameter int REPEAT_CYCLES = 15_000_000
`endif
) (
  input  logic             MAX10_CLK1_50,
  input  logic             rst,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic [2:0]       enable,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y,
  output logic [POS_W-1:0] pos_z,
  output logic             busy
);

  localparam int TICK_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [TICK_W-1:0] C_TICK_LAST = TICK_W'(RAMP_DIV - 1);
  localparam logic [POS_W-1:0]  C_STEP      = POS_W'(STEP);
  localparam logic [POS_W-1:0]  C_POS_MIN   = POS_W'(POS_MIN);
  localparam logic [POS_W-1:0]  C_POS_MAX   = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0]  C_POS_RST   = POS_W'(POS_RST);

  logic              up_press;
  logic              dn_press;
  logic [TICK_W-1:0] tick_q;
  logic              tick;
  logic [POS_W-1:0]  tgt_q [3];
  logic [POS_W-1:0]  tgt_d [3];
  logic [POS_W-1:0]  pos_q [3];
  logic [POS_W-1:0]  pos_d [3];
  logic              busy_q;
  logic              busy_d;

  btn_debounce #(
    .DEB_CYCLES    (DEB_CYCLES)
`ifdef SERVO_AUTOREPEAT_EN
    ,
    .REPEAT_CYCLES (REPEAT_CYCLES)
`endif
  ) u_deb_up (
    .clk_i   (MAX10_CLK1_50),
    .rst_ni  (rst),
    .btn_ni  (btn_up),
    .press_o (up_press)
  );

  btn_debounce #(
    .DEB_CYCLES    (DEB_CYCLES)
`ifdef SERVO_AUTOREPEAT_EN
    ,
    .REPEAT_CYCLES (REPEAT_CYCLES)
`endif
  ) u_deb_dn (
    .clk_i   (MAX10_CLK1_50),
    .rst_ni  (rst),
    .btn_ni  (btn_down),
    .press_o (dn_press)
  );

  assign tick = (tick_q == C_TICK_LAST);

  // Free-running ramp divider; target changes never disturb its phase
  always_ff @(posedge MAX10_CLK1_50 or negedge rst) begin
    if (!rst) begin
      tick_q <= '0;
    end else if (tick) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_q + 1'b1;
    end
  end

  // Next targets from press pulses and next positions from the ramp tick;
  // busy is derived from the next-state values so it lines up with pos_*
  always_comb begin
    busy_d = 1'b0;
    for (int a = 0; a < 3; a++) begin
      tgt_d[a] = tgt_q[a];
      if (enable[a] && (up_press != dn_press)) begin
        tgt_d[a] = up_press ? sat_add(tgt_q[a], C_STEP, C_POS_MAX)
                            : sat_sub(tgt_q[a], C_STEP, C_POS_MIN);
      end
      pos_d[a] = pos_q[a];
      if (tick) begin
        if (pos_q[a] < tgt_q[a]) begin
          pos_d[a] = pos_q[a] + 1'b1;
        end else if (pos_q[a] > tgt_q[a]) begin
          pos_d[a] = pos_q[a] - 1'b1;
        end
      end
      if (pos_d[a] != tgt_d[a]) begin
        busy_d = 1'b1;
      end
    end
  end

  // Target, position and busy registers
  always_ff @(posedge MAX10_CLK1_50 or negedge rst) begin
    if (!rst) begin
      for (int a = 0; a < 3; a++) begin
        tgt_q[a] <= C_POS_RST;
        pos_q[a] <= C_POS_RST;
      end
      busy_q <= 1'b0;
    end else begin
      for (int a = 0; a < 3; a++) begin
        tgt_q[a] <= tgt_d[a];
        pos_q[a] <= pos_d[a];
      end
      busy_q <= busy_d;
    end
  end

  assign pos_x = pos_q[0];
  assign pos_y = pos_q[1];
  assign pos_z = pos_q[2];
  assign busy  = busy_q;

endmodule
`default_nettype wire

// File: doc/servo_pos_ctrl.md
# servo_pos_ctrl

Upstream command stage for the robot-arm servo PWM generators. Turns the two raw push-buttons and three per-axis enable switches into three slew-limited pulse-width commands (microseconds) for the X, Y and Z PWM stages. Each button is debounced by its own FSM. Each press moves the enabled axes' targets by a fixed step, and the outputs ramp toward the targets at a fixed rate.

## Interface
- DEB_CYCLES, 1_000_000, consecutive stable samples required to accept a button level (20 ms at 50 MHz)
- RAMP_DIV, 50_000, clock cycles per ramp tick (1 ms)
- STEP, 10, target change per press, in µs
- POS_MIN, 500, lower saturation limit of target, in µs
- POS_MAX, 2500, upper saturation limit of target, in µs
- POS_RST, 1500, reset value of targets and outputs, in µs
- REPEAT_CYCLES, 15_000_000, hold time per auto-repeat event (macro only)

- MAX10_CLK1_50  in  1  system clock, 50 MHz
- rst  in  1  asynchronous, active-low reset
- btn_up  in  1  raw KEY input, active-low (0 = pressed), asynchronous
- btn_down  in  1  raw KEY input, active-low, asynchronous
- enable  in  3  per-axis enable [0]=X [1]=Y [2]=Z (SW), sampled on press events only
- pos_x  out  12  X pulse-width command, µs
- pos_y  out  12  Y pulse-width command, µs
- pos_z  out  12  Z pulse-width command, µs
- busy  out  1  high while any pos_* differs from its target

## Operation
- Each button passes through a 2-flop synchronizer, then its debounce FSM.
- Debounce FSM states:
  - RELEASED: sync input 0 → PRESS_WAIT, counter cleared.
  - PRESS_WAIT: input 1 → RELEASED; counter reaches DEB_CYCLES-1 → HELD, emitting a one-cycle press pulse.
  - HELD: input 1 → RELEASE_WAIT, counter cleared.
  - RELEASE_WAIT: input 0 → HELD; counter reaches DEB_CYCLES-1 → RELEASED.
- Press handling, for each axis with enable=1:
  - up pulse: target = min(target+STEP, POS_MAX).
  - down pulse: target = max(target−STEP, POS_MIN).
  - Compute in 13 bits, then saturate.
  - Up and down pulses in the same cycle: no change.
  - Axes with enable=0 keep their target.
- Ramp:
  - Free-running tick counter 0..RAMP_DIV-1.
  - On the tick (counter = RAMP_DIV-1), each pos_* moves 1 µs toward its target; equal means no change.
  - A target change never resets the tick counter.
- busy = OR over axes of (pos != target), registered.
- Reset (rst=0, asynchronous):
  - FSMs go to RELEASED; all counters are 0.
  - Targets and pos_x/y/z = POS_RST; busy = 0.
  - Release of reset is synchronized by the sync flops (FSMs see 1 for at least 2 cycles).

## Timing
- All outputs are registered.
- Press latency:
  - Input low and stable at cycle 0 → press pulse at cycle 2+DEB_CYCLES.
  - Target updates on the next edge.
  - First pos_* step occurs on the next ramp tick.
- A glitch shorter than DEB_CYCLES in PRESS_WAIT or RELEASE_WAIT returns to the prior stable state with no pulse.
- Full travel POS_MIN→POS_MAX takes 2000 ticks (2 s at defaults).
- A target change mid-ramp is allowed; the ramp redirects toward the new target on the next tick.
- Reset mid-ramp abandons the motion immediately.

## Configuration
- SERVO_AUTOREPEAT_EN defined:
  - In HELD, a repeat counter runs.
  - Every REPEAT_CYCLES of continuous HELD, another press pulse is emitted.
  - The repeat counter clears on leaving HELD.
- Not defined: exactly one press pulse per debounced press; no repeat logic synthesized.

## Structure
- Package servo_pkg holds:
  - POS_W = 12.
  - Default POS_MIN/POS_MAX/POS_RST/STEP.
  - Debounce state enum {RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT}.
- Sub-module btn_debounce: synchronizer, FSM, counter and optional repeat logic, with a one-cycle press output. It is instantiated twice.
- Target registers, saturation, tick counter and ramp logic live in servo_pos_ctrl.

## Test plan
Bench parameters: DEB_CYCLES=4, RAMP_DIV=2, STEP=10.
- Reset: all pos_* = 1500 and busy = 0; no change with buttons idle for 1000 cycles.
- enable=3'b001, btn_up held low 20 cycles → X target 1510; pos_x steps 1501..1510 on successive ticks; busy falls after 1510; Y and Z stay 1500.
- btn_down 2-cycle low glitch → no press pulse, targets unchanged.
- enable=3'b111, 110 down presses → all targets saturate at 500; pos_* settle at 500 and never go below.
- Simultaneous debounced up and down pulses in the same cycle → targets unchanged.
- With SERVO_AUTOREPEAT_EN and REPEAT_CYCLES=50, up held 220 cycles → 5 total increments (1 initial + 4 repeats).
